// File: rtl/vga_scaled_scanout_if.sv
// Bundle between the scan-out engine and its memory, pixel sources and DAC pins.
// master = scan-out engine, slave = surrounding frame memory / sources / pins.
interface vga_scaled_scanout_if #(
    parameter int COLOR_WIDTH = 4,
    parameter int ADDR_W      = 19
);
    logic [1:0]               iScale;
    logic [1:0]               iSrcSel;
    logic [3*COLOR_WIDTH-1:0] iMemData;
    logic [3*COLOR_WIDTH-1:0] iAltRGB;
    logic [ADDR_W-1:0]        oAddr;
    logic                     oHS;
    logic                     oVS;
    logic                     oBLANK_n;
    logic [COLOR_WIDTH-1:0]   oR;
    logic [COLOR_WIDTH-1:0]   oG;
    logic [COLOR_WIDTH-1:0]   oB;
    logic                     oFrameStart;

    modport master (
        input  iScale, iSrcSel, iMemData, iAltRGB,
        output oAddr, oHS, oVS, oBLANK_n, oR, oG, oB, oFrameStart
    );

    modport slave (
        output iScale, iSrcSel, iMemData, iAltRGB,
        input  oAddr, oHS, oVS, oBLANK_n, oR, oG, oB, oFrameStart
    );
endinterface

// File: rtl/vga_scaled_scanout.sv
// Parametrised VGA scan-out: timing counters, scaled frame-buffer addressing, source mux and
// latency-matched sync/blank/RGB. Define VGA_TESTBARS_EN to add colour bars on source 2.
module vga_scaled_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int COLOR_WIDTH = 4,
    parameter int ADDR_W      = 19,
    parameter int MEM_LAT     = 1
) (
    input logic                  iVGA_CLK,
    input logic                  iRST_n,
    vga_scaled_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = COLOR_WIDTH;

    localparam logic [HW-1:0]     H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] H_ACT_A = ADDR_W'(H_ACTIVE);

    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic       fs;
`ifdef VGA_TESTBARS_EN
        logic [2:0] bar;
`endif
    } stage_t;

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W-1:0] stride;
    logic [VW-1:0]     row_mask;
    logic [1:0]        scale_q, sel_q, scale_cur;
    logic              frame_start, vis_d;

    stage_t            cur_stage;
    stage_t            pipe_q [MEM_LAT];
    stage_t            last_stage;
    logic [3*CW-1:0]   src_rgb, rgb_q;
    logic              hs_q, vs_q, blank_n_q, fs_q;

    // The scale used for the step out of (0,0) is the value being latched on that same edge.
    always_comb begin
        frame_start = (h_q == '0) && (v_q == '0);
        scale_cur   = frame_start ? bus.iScale : scale_q;
        row_mask    = ~({VW{1'b1}} << scale_cur);
        stride      = H_ACT_A >> scale_cur;
        h_d         = h_q + 1'b1;
        v_d         = v_q;
        row_base_d  = row_base_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            if ((v_q < V_ACT) && ((v_q & row_mask) == row_mask)) begin
                row_base_d = row_base_q + stride;
            end
        end
        if ((h_d == '0) && (v_d == '0)) begin
            row_base_d = '0;
        end
        vis_d    = (h_d < H_ACT) && (v_d < V_ACT);
        addr_sum = {1'b0, row_base_d} + {1'b0, ADDR_W'(h_d >> scale_cur)};
        addr_d   = vis_d ? addr_sum[ADDR_W-1:0] : addr_q;
    end

`ifdef VGA_TESTBARS_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [6:0]      bar_ge;
    logic [2:0]      bar_idx;
    logic [3*CW-1:0] bar_rgb;

    // Thermometer of bar boundaries; its population count is the bar index.
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi-1] = (h_q >= HW'(gi * BAR_W));
    end

    always_comb begin
        bar_idx = '0;
        for (int k = 0; k < 7; k++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[k]};
        end
    end

    assign bar_rgb = {{CW{~last_stage.bar[0]}}, {CW{~last_stage.bar[2]}}, {CW{~last_stage.bar[1]}}};
`endif

    always_comb begin
        cur_stage     = '0;
        cur_stage.vis = (h_q < H_ACT) && (v_q < V_ACT);
        cur_stage.hs  = (h_q >= HS_BEG) && (h_q < HS_END);
        cur_stage.vs  = (v_q >= VS_BEG) && (v_q < VS_END);
        cur_stage.fs  = frame_start;
`ifdef VGA_TESTBARS_EN
        cur_stage.bar = bar_idx;
`endif
    end

    assign last_stage = pipe_q[MEM_LAT-1];

    always_comb begin
        src_rgb = '0;
        case (sel_q)
            2'd0:    src_rgb = bus.iMemData;
            2'd1:    src_rgb = bus.iAltRGB;
`ifdef VGA_TESTBARS_EN
            2'd2:    src_rgb = bar_rgb;
`endif
            default: src_rgb = '0;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_q        <= '0;
            v_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            scale_q    <= '0;
            sel_q      <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                pipe_q[k] <= '0;
            end
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            if (frame_start) begin
                scale_q <= bus.iScale;
                sel_q   <= bus.iSrcSel;
            end
            pipe_q[0] <= cur_stage;
            for (int k = 1; k < MEM_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
            hs_q      <= last_stage.hs ? HS_POL : ~HS_POL;
            vs_q      <= last_stage.vs ? VS_POL : ~VS_POL;
            blank_n_q <= last_stage.vis;
            fs_q      <= last_stage.fs;
            rgb_q     <= last_stage.vis ? src_rgb : '0;
        end
    end

    // An address that does not fit ADDR_W means the parameter set is inconsistent.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST_n && vis_d) begin
            assert (!addr_sum[ADDR_W]);
        end
    end

    assign bus.oAddr       = addr_q;
    assign bus.oHS         = hs_q;
    assign bus.oVS         = vs_q;
    assign bus.oBLANK_n    = blank_n_q;
    assign bus.oFrameStart = fs_q;
    assign bus.oR          = rgb_q[CW-1:0];
    assign bus.oG          = rgb_q[2*CW-1:CW];
    assign bus.oB          = rgb_q[3*CW-1:2*CW];
endmodule

// File: tb/tb_vga_scaled_scanout.sv
// Directed bench for vga_scaled_scanout on a reduced 64x16 timing set (80x22 total),
// with a MEM_LAT=1 and a MEM_LAT=3 instance fed by frame memories returning the address.
module tb_vga_scaled_scanout;
    localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
    localparam int VA = 16, VF = 2, VSY = 2, VB = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_scaled_scanout_if #(.COLOR_WIDTH(4), .ADDR_W(19)) bus ();
    vga_scaled_scanout_if #(.COLOR_WIDTH(4), .ADDR_W(19)) bus2 ();

    vga_scaled_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_WIDTH(4), .ADDR_W(19), .MEM_LAT(1)
    ) dut (.iVGA_CLK(clk), .iRST_n(rst_n), .bus(bus));

    vga_scaled_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_WIDTH(4), .ADDR_W(19), .MEM_LAT(3)
    ) dut3 (.iVGA_CLK(clk), .iRST_n(rst_n), .bus(bus2));

    // Frame memories whose contents equal the address, one and three clocks of read latency.
    logic [11:0] mem1_q;
    logic [11:0] mem3_q [3];
    always @(posedge clk) begin
        mem1_q    <= bus.oAddr[11:0];
        mem3_q[0] <= bus2.oAddr[11:0];
        mem3_q[1] <= mem3_q[0];
        mem3_q[2] <= mem3_q[1];
    end
    assign bus.iMemData  = mem1_q;
    assign bus2.iMemData = mem3_q[2];

    function automatic logic [11:0] rgb1();
        return {bus.oB, bus.oG, bus.oR};
    endfunction

    function automatic logic [11:0] rgb2();
        return {bus2.oB, bus2.oG, bus2.oR};
    endfunction

    function automatic logic [11:0] bar_exp(input int h);
`ifdef VGA_TESTBARS_EN
        case (h / (HA / 8))
            0: return 12'hFFF;
            1: return 12'h0FF;
            2: return 12'hFF0;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'h00F;
            6: return 12'hF00;
            default: return 12'h000;
        endcase
`else
        return (h < 0) ? 12'hFFF : 12'h000;
`endif
    endfunction

    task automatic do_reset(input logic [1:0] scale, input logic [1:0] sel);
        rst_n       = 1'b0;
        bus.iScale  = scale;
        bus.iSrcSel = sel;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.oFrameStart !== 1'b1) begin
            n_err++;
            $display("FAIL reset_framestart got %b want 1", bus.oFrameStart);
        end
    endtask

    // Caller sits on output pixel (0,0) of a frame; returns on (0,0) of the next one.
    task automatic scan_frame(input int which, input int s, input int chg_line,
                              input logic [1:0] chg_val, input string name);
        int h, v;
        logic [12:0] got, exp;
        for (int i = 0; i < FT; i++) begin
            h = i % HT;
            v = i / HT;
            if (chg_line >= 0 && h == 0 && v == chg_line) bus.iScale = chg_val;
            if (which == 1) got = {bus2.oBLANK_n, rgb2()};
            else            got = {bus.oBLANK_n, rgb1()};
            if (h < HA && v < VA) exp = {1'b1, 12'((h >> s) + (v >> s) * (HA >> s))};
            else                  exp = 13'h0000;
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s h=%0d v=%0d got blank/rgb %h want %h", name, h, v, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.iScale   = 2'd0;
        bus.iSrcSel  = 2'd0;
        bus.iAltRGB  = 12'h5A3;
        bus2.iScale  = 2'd0;
        bus2.iSrcSel = 2'd0;
        bus2.iAltRGB = 12'h000;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({bus.oHS, bus.oVS, bus.oBLANK_n, bus.oFrameStart, rgb1()} !== 16'hC000) begin
            n_err++;
            $display("FAIL reset_hold got %h want c000",
                     {bus.oHS, bus.oVS, bus.oBLANK_n, bus.oFrameStart, rgb1()});
        end
        n_vec++;
        if (bus.oAddr !== 19'd0) begin
            n_err++;
            $display("FAIL reset_addr got %0d want 0", bus.oAddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.oBLANK_n, bus.oFrameStart} !== 2'b00) begin
            n_err++;
            $display("FAIL release_plus1 got %b want 00", {bus.oBLANK_n, bus.oFrameStart});
        end
        @(negedge clk);
        n_vec++;
        if ({bus.oBLANK_n, bus.oFrameStart} !== 2'b11) begin
            n_err++;
            $display("FAIL release_plus2 got %b want 11", {bus.oBLANK_n, bus.oFrameStart});
        end
        @(negedge clk);
        n_vec++;
        if ({bus.oFrameStart, bus2.oBLANK_n} !== 2'b00) begin
            n_err++;
            $display("FAIL release_plus3 got fs/blank3 %b want 00", {bus.oFrameStart, bus2.oBLANK_n});
        end
        @(negedge clk);
        n_vec++;
        if ({bus2.oBLANK_n, bus2.oFrameStart} !== 2'b11) begin
            n_err++;
            $display("FAIL lat3_release_plus4 got %b want 11", {bus2.oBLANK_n, bus2.oFrameStart});
        end
    endtask

    task automatic test_line_timing();
        int blank_line, blank_frame, hs_first, hs_cnt, vs_cnt, fs_cnt, fs_pos;
        blank_line = 0; blank_frame = 0; hs_first = -1; hs_cnt = 0;
        vs_cnt = 0; fs_cnt = 0; fs_pos = -1;
        do_reset(2'd0, 2'd0);
        for (int i = 0; i < FT + HT; i++) begin
            if (i < HT) begin
                if (bus.oBLANK_n) blank_line++;
                if (!bus.oHS) begin
                    if (hs_first < 0) hs_first = i;
                    hs_cnt++;
                end
            end
            if (i < FT && bus.oBLANK_n) blank_frame++;
            if (i >= HT) begin
                if (!bus.oVS) vs_cnt++;
                if (bus.oFrameStart) begin
                    fs_cnt++;
                    fs_pos = i;
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (blank_line !== 64) begin n_err++; $display("FAIL line_blank got %0d want 64", blank_line); end
        n_vec++;
        if (hs_first !== 68) begin n_err++; $display("FAIL hs_start got %0d want 68", hs_first); end
        n_vec++;
        if (hs_cnt !== 8) begin n_err++; $display("FAIL hs_width got %0d want 8", hs_cnt); end
        n_vec++;
        if (vs_cnt !== 160) begin n_err++; $display("FAIL vs_width got %0d want 160", vs_cnt); end
        n_vec++;
        if (blank_frame !== 1024) begin n_err++; $display("FAIL frame_blank got %0d want 1024", blank_frame); end
        n_vec++;
        if ({fs_cnt, fs_pos} !== {32'd1, 32'd1760}) begin
            n_err++;
            $display("FAIL frame_period got count %0d pos %0d want 1 at 1760", fs_cnt, fs_pos);
        end
    endtask

    task automatic test_scale();
        do_reset(2'd1, 2'd0);
        scan_frame(0, 1, -1, 2'd0, "scale1");
        repeat (15 * HT + 63 + 5) @(negedge clk);
        n_vec++;
        if (bus.oAddr !== 19'd255) begin
            n_err++;
            $display("FAIL addr_hold got %0d want 255", bus.oAddr);
        end
    endtask

    task automatic test_scale_change();
        do_reset(2'd0, 2'd0);
        scan_frame(0, 0, 4, 2'd2, "scale_midframe");
        scan_frame(0, 2, -1, 2'd0, "scale2_next");
    endtask

    task automatic test_sources();
        logic [12:0] got, exp;
        logic [11:0] pix;
        for (int sel = 1; sel < 4; sel++) begin
            do_reset(2'd0, 2'(sel));
            for (int h = 0; h < HT; h++) begin
                if (sel == 1)      pix = 12'h5A3;
                else if (sel == 2) pix = bar_exp(h);
                else               pix = 12'h000;
                exp = (h < HA) ? {1'b1, pix} : 13'h0000;
                got = {bus.oBLANK_n, rgb1()};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL source%0d h=%0d got %h want %h", sel, h, got, exp);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_memlat3();
        do_reset(2'd0, 2'd0);
        @(negedge clk);
        n_vec++;
        if ({bus2.oBLANK_n, bus2.oFrameStart} !== 2'b00) begin
            n_err++;
            $display("FAIL lat3_pre got %b want 00", {bus2.oBLANK_n, bus2.oFrameStart});
        end
        @(negedge clk);
        n_vec++;
        if (bus2.oFrameStart !== 1'b1) begin
            n_err++;
            $display("FAIL lat3_framestart got %b want 1", bus2.oFrameStart);
        end
        scan_frame(1, 0, -1, 2'd0, "memlat3");
    endtask

    task automatic test_reset_midline();
        do_reset(2'd0, 2'd1);
        repeat (10) @(negedge clk);
        n_vec++;
        if ({bus.oBLANK_n, rgb1()} !== 13'h15A3) begin
            n_err++;
            $display("FAIL midline_pre got %h want 15a3", {bus.oBLANK_n, rgb1()});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.oHS, bus.oVS, bus.oBLANK_n, bus.oFrameStart, rgb1()} !== 16'hC000 ||
            bus.oAddr !== 19'd0) begin
            n_err++;
            $display("FAIL midline_reset got %h addr %0d want c000 addr 0",
                     {bus.oHS, bus.oVS, bus.oBLANK_n, bus.oFrameStart, rgb1()}, bus.oAddr);
        end
        n_vec++;
        if ({bus2.oHS, bus2.oVS, bus2.oBLANK_n, bus2.oFrameStart, rgb2()} !== 16'hC000 ||
            bus2.oAddr !== 19'd0) begin
            n_err++;
            $display("FAIL midline_reset_lat3 got %h addr %0d want c000 addr 0",
                     {bus2.oHS, bus2.oVS, bus2.oBLANK_n, bus2.oFrameStart, rgb2()}, bus2.oAddr);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_scale();
        test_scale_change();
        test_sources();
        test_memlat3();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1);
    end
endmodule
